// File: rtl/sigbuff_ctrl.sv
// Frame buffer between level generator / hard limiter and the FIR front-end.
// Single-clock dual-port RAM with two-stage read pipeline, iteration sequencing and sticky error flags.
module sigbuff_ctrl #(
    parameter int DATA_WIDTH         = 16,
    parameter int MAX_SAMPLES_IN_RAM = 255,
    parameter int ADDR_WIDTH         = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4:0]            iter_num,
    input  logic                  input_mux,
    input  logic                  input_enable,
    input  logic                  output_enable,
    input  logic [DATA_WIDTH-1:0] lvl_gen_data,
    input  logic                  lvl_gen_valid,
    input  logic [DATA_WIDTH-1:0] limiter_data,
    input  logic                  limiter_valid,
    output logic [DATA_WIDTH-1:0] fir_data,
    output logic                  fir_valid,
    output logic                  iter_start,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic                  overflow,
    output logic                  underrun
);

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(MAX_SAMPLES_IN_RAM - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH + 1)'(MAX_SAMPLES_IN_RAM);
    localparam logic [ADDR_WIDTH:0]   CNT_SAT   = (ADDR_WIDTH + 1)'(MAX_SAMPLES_IN_RAM + 1);

    logic [DATA_WIDTH-1:0]         r_mem [0:MAX_SAMPLES_IN_RAM-1];
    logic [MAX_SAMPLES_IN_RAM-1:0] r_written;
    logic [ADDR_WIDTH-1:0]         r_wr_ptr;
    logic [ADDR_WIDTH-1:0]         r_rd_ptr;
    logic [ADDR_WIDTH:0]           r_wr_cnt;
    logic [4:0]                    r_iter_q;
    logic [DATA_WIDTH-1:0]         r_rd_data;
    logic                          r_rd_vld;
    logic [DATA_WIDTH-1:0]         r_fir_data;
    logic                          r_fir_valid;
    logic                          r_iter_start;
    logic                          r_overflow;
    logic                          r_underrun;

    logic                          w_wr_en;
    logic [DATA_WIDTH-1:0]         w_wr_data;
    logic                          w_iter_chg;

    always_comb begin
        w_wr_en    = input_enable & (input_mux ? limiter_valid : lvl_gen_valid);
        w_wr_data  = input_mux ? limiter_data : lvl_gen_data;
        w_iter_chg = (iter_num != r_iter_q);
    end

    // RAM is never cleared; non-blocking read of the old word gives read-first behaviour.
    always_ff @(posedge clock) begin
        if (reset && w_wr_en)
            r_mem[r_wr_ptr] <= w_wr_data;
        if (output_enable)
            r_rd_data <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_wr_cnt     <= '0;
            r_iter_q     <= '0;
            r_written    <= '0;
            r_rd_vld     <= 1'b0;
            r_fir_data   <= '0;
            r_fir_valid  <= 1'b0;
            r_iter_start <= 1'b0;
            r_overflow   <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_iter_q     <= iter_num;
            r_iter_start <= w_iter_chg;

            if (w_wr_en) begin
                r_written[r_wr_ptr] <= 1'b1;
                if (r_wr_cnt == CNT_FULL)
                    r_overflow <= 1'b1;
            end

            // Iteration change wins over any pointer/count advance on the same edge.
            if (w_iter_chg) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_wr_cnt <= '0;
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
                    if (r_wr_cnt != CNT_SAT)
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                end
                if (output_enable)
                    r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end

            if (output_enable && !r_written[r_rd_ptr])
                r_underrun <= 1'b1;

            r_rd_vld    <= output_enable;
            r_fir_valid <= r_rd_vld;
            if (r_rd_vld)
                r_fir_data <= r_rd_data;
        end
    end

    always_comb begin
        fir_data   = r_fir_data;
        fir_valid  = r_fir_valid;
        iter_start = r_iter_start;
        wr_ptr     = r_wr_ptr;
        rd_ptr     = r_rd_ptr;
        overflow   = r_overflow;
        underrun   = r_underrun;
    end

endmodule
